count_checker: RTL
==================

// Module: count_checker
// PURPOSE
//  Sink-side monitor for the free-running counter's q bus. Each valid cycle it
//  samples the bus and checks that it advances by +1 mod 2^WIDTH (F->0 wrap).
//  It locks after a run of good samples, flags and counts sequence errors, and
//  drops lock after repeated misses. It sits beside the counter in system and
//  bench builds as a self-checking receiver for the q stream.
// PARAMETERS
//  WIDTH     4  width of observed count bus
//  LOCK_CNT  2  consecutive correct increments needed to enter LOCK (>=1)
//  MAX_MISS  3  consecutive mismatches in LOCK that force return to HUNT (>=1)
//  ERRCNT_W  8  width of saturating error counter
// PORTS
//  ck       in   1         clock, rising edge
//  res      in   1         asynchronous, active-low reset
//  vld      in   1         q_in valid this cycle; nothing updates when 0
//  q_in     in   WIDTH     observed counter value
//  clr      in   1         synchronous clear of err_cnt (and sticky flag)
//  locked   out  1         1 while FSM is in LOCK
//  err      out  1         one-cycle pulse per mismatch seen in LOCK
//  err_cnt  out  ERRCNT_W  mismatch count in LOCK, saturates at all-ones
// BEHAVIOUR
//  - res=0 (async): state=HUNT, exp=0, good=0, miss=0, locked=0, err=0, err_cnt=0.
//  - All outputs are registered. They update on the same ck edge that samples
//    q_in with vld=1 and are visible after that edge (1-cycle latency).
//  - Arithmetic: exp <= (q_in + 1) mod 2^WIDTH. For WIDTH=4, q_in=F gives exp=0.
//  - Every sample with vld=1 reloads exp from q_in+1 (resync to observed value).
//  - Cycles with vld=0 hold all state. They are not a miss and do not break a run.
//  - err is 0 in every cycle without a LOCK-state mismatch.
//  - HUNT: on vld -> exp<=q_in+1, good<=0, go to SYNC.
//  - SYNC, match (q_in==exp): good++. When good reaches LOCK_CNT -> LOCK,
//    locked<=1, miss<=0.
//  - SYNC, mismatch: good<=0, stay in SYNC. No err pulse, no err_cnt change.
//  - LOCK, match: miss<=0.
//  - LOCK, mismatch: err<=1 for one cycle, err_cnt++ (saturating), miss++.
//    When miss reaches MAX_MISS -> HUNT, locked<=0.
//  - clr and mismatch in the same cycle: err still pulses, but clr wins and
//    err_cnt<=0. clr does not affect state, exp or locked.
//  - res asserted mid-operation returns to the reset values immediately.
//    Relock needs a full HUNT -> SYNC sequence.
// CONFIGURATION
//  STICKY_ERR_EN defined:
//    - Adds output port err_flag (1 bit, reset 0).
//    - err_flag sets on any err pulse and stays set until clr=1 or res=0.
//    - If clr and a set event coincide, err_flag ends at 0.
//  STICKY_ERR_EN undefined:
//    - err_flag port and its logic are absent.
//    - All other behaviour is identical.
// TESTING
//  - Release res; vld=1; q_in=3,4,5 on successive cycles
//    -> locked rises after the sample of 5; err=0; err_cnt=0.
//  - While locked, feed E,F,0,1 -> no err, locked stays 1 (wrap accepted).
//  - While locked, feed 7,8,A,B -> err pulses once (after A); err_cnt=1; locked=1.
//  - While locked, feed 3 mismatches (2,9,4) -> err_cnt +3; locked falls after
//    the third; state returns to HUNT.
//  - While locked, vld=0 for 5 cycles, then resume at the next expected value
//    -> no err, locked held throughout.
//  - Force 300 mismatches with periodic relock -> err_cnt saturates at 0xFF.
//    Then clr=1 in a cycle that also has a mismatch -> err_cnt=0 and err still
//    pulses. With STICKY_ERR_EN, err_flag=1 before the clr and 0 after it.
//  - Pull res low mid-lock -> locked, err and err_cnt all 0 immediately.

Source files
------------

// File: rtl/count_checker.sv
// Sink-side monitor for a free-running counter bus: locks after a run of +1 steps,
// pulses and counts mismatches while locked. Optional sticky error flag via STICKY_ERR_EN.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int MAX_MISS = 3,
  parameter int ERRCNT_W = 8
) (
  input  logic                ck,
  input  logic                res,
  input  logic                vld,
  input  logic [WIDTH-1:0]    q_in,
  input  logic                clr,
  output logic                locked,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt
`ifdef STICKY_ERR_EN
  ,
  output logic                err_flag
`endif
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);
  // Compare against count-1 so the transition fires on the sample that completes the run.
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISS - 1);

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      exp_q, exp_nxt;
  logic [GOOD_W-1:0]     good, good_nxt;
  logic [MISS_W-1:0]     miss, miss_nxt;
  logic                  locked_nxt, err_nxt;
  logic [ERRCNT_W-1:0]   err_cnt_nxt;
  logic                  match;

  assign match = (q_in == exp_q);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_nxt   = state;
    exp_nxt     = exp_q;
    good_nxt    = good;
    miss_nxt    = miss;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    if (vld) begin
      exp_nxt = q_in + 1'b1;
      unique case (state)
        HUNT: begin
          good_nxt  = '0;
          state_nxt = SYNC;
        end
        SYNC: begin
          if (!match) begin
            good_nxt = '0;
          end else if (good == GOOD_LAST) begin
            state_nxt = LOCK;
            miss_nxt  = '0;
          end else begin
            good_nxt = good + 1'b1;
          end
        end
        LOCK: begin
          if (match) begin
            miss_nxt = '0;
          end else begin
            err_nxt = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + 1'b1;
            if (miss == MISS_LAST) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss + 1'b1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
    if (clr) err_cnt_nxt = '0;
    locked_nxt = (state_nxt == LOCK);
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state   <= HUNT;
      exp_q   <= '0;
      good    <= '0;
      miss    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state   <= state_nxt;
      exp_q   <= exp_nxt;
      good    <= good_nxt;
      miss    <= miss_nxt;
      locked  <= locked_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

`ifdef STICKY_ERR_EN
  always_ff @(posedge ck or negedge res) begin
    if (!res)          err_flag <= 1'b0;
    else if (clr)      err_flag <= 1'b0;
    else if (err_nxt)  err_flag <= 1'b1;
  end
`endif

endmodule
